ctrl_pb200: RTL and testbench

CTRL_PB200 -- requirements
Module: ctrl_pb200

---
 rtl/ctrl_pb200.sv | 136 +++++++++++++
 tb/tb_ctrl_pb200.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pb200.sv
// Sequencing controller for a single-MAC biquad datapath: one start runs five MAC
// steps (M1..M5) and a history update (UPD), and flags any start that arrives while busy.
module ctrl_pb200 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [2:0] controlS,
    output logic [1:0] controlC,
    output logic [2:0] controlZ,
    output logic       en_acum1,
    output logic       en_fk,
    output logic       en_acum2,
    output logic       en_acum3,
    output logic       en_yk,
    output logic       en_shift,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_M5   = 3'd5,
        S_UPD  = 3'd6
    } state_t;

    typedef struct packed {
        logic [2:0] sel_s;
        logic [1:0] sel_c;
        logic [2:0] sel_z;
        logic       en_acum1;
        logic       en_fk;
        logic       en_acum2;
        logic       en_acum3;
        logic       en_yk;
        logic       en_shift;
        logic       busy;
        logic       done;
    } ctrl_t;

    // Moore output table; any encoding outside the table decodes to all-zero.
    function automatic ctrl_t decode(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            S_IDLE: c = '0;
            S_M1: begin
                c.sel_s = 3'd1; c.sel_c = 2'd1; c.sel_z = 3'd1;
                c.en_acum1 = 1'b1; c.busy = 1'b1;
            end
            S_M2: begin
                c.sel_s = 3'd2; c.sel_c = 2'd2; c.sel_z = 3'd3;
                c.en_fk = 1'b1; c.busy = 1'b1;
            end
            S_M3: begin
                c.sel_s = 3'd3; c.sel_c = 2'd3; c.sel_z = 3'd0;
                c.en_acum2 = 1'b1; c.busy = 1'b1;
            end
            S_M4: begin
                c.sel_s = 3'd4; c.sel_c = 2'd1; c.sel_z = 3'd4;
                c.en_acum3 = 1'b1; c.busy = 1'b1;
            end
            S_M5: begin
                c.sel_s = 3'd5; c.sel_c = 2'd2; c.sel_z = 3'd5;
                c.en_yk = 1'b1; c.busy = 1'b1;
            end
            S_UPD: begin
                c.en_shift = 1'b1; c.busy = 1'b1; c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Kept as a plain vector so unused encodings remain representable and recoverable.
    logic [2:0] state_q;
    state_t     state_d;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic       overrun_q;
    logic       overrun_d;

    // Next-state sequencing, output pre-decode and overrun accumulation.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_M1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_M1:    state_d = S_M2;
            S_M2:    state_d = S_M3;
            S_M3:    state_d = S_M4;
            S_M4:    state_d = S_M5;
            S_M5:    state_d = S_UPD;
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ctrl_d    = decode(state_d);
        overrun_d = overrun_q | (start & (state_q != S_IDLE));
    end

    // State, registered outputs (decoded from the next state) and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            overrun_q <= overrun_d;
        end
    end

    assign controlS = ctrl_q.sel_s;
    assign controlC = ctrl_q.sel_c;
    assign controlZ = ctrl_q.sel_z;
    assign en_acum1 = ctrl_q.en_acum1;
    assign en_fk    = ctrl_q.en_fk;
    assign en_acum2 = ctrl_q.en_acum2;
    assign en_acum3 = ctrl_q.en_acum3;
    assign en_yk    = ctrl_q.en_yk;
    assign en_shift = ctrl_q.en_shift;
    assign busy     = ctrl_q.busy;
    assign done     = ctrl_q.done;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_ctrl_pb200.sv
// Bench for ctrl_pb200: phase-counter reference model, Q14 biquad datapath driven by
// the controller's selects/enables, and a directly computed golden biquad.
module tb_ctrl_pb200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] controlS;
    logic [1:0] controlC;
    logic [2:0] controlZ;
    logic       en_acum1, en_fk, en_acum2, en_acum3, en_yk, en_shift;
    logic       busy, done, overrun;

    always #5 clk = ~clk;

    ctrl_pb200 dut (
        .clk(clk), .reset(reset), .start(start),
        .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
        .en_acum1(en_acum1), .en_fk(en_fk), .en_acum2(en_acum2),
        .en_acum3(en_acum3), .en_yk(en_yk), .en_shift(en_shift),
        .busy(busy), .done(done), .overrun(overrun)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = idle, 1..6 = steps after an accepted start, 7 = illegal.
    int phase = 0;
    logic ovr_m = 1'b0;
    int exp_s [0:6] = '{0, 1, 2, 3, 4, 5, 0};
    int exp_c [0:6] = '{0, 1, 2, 3, 1, 2, 0};
    int exp_z [0:6] = '{0, 1, 3, 0, 4, 5, 0};
    logic [5:0] exp_en [0:6] = '{6'b000000, 6'b100000, 6'b010000, 6'b001000,
                                 6'b000100, 6'b000010, 6'b000001};

    // Datapath model (Q14 coefficients) and golden biquad.
    localparam longint A1 = 32112;
    localparam longint A2 = -15736;
    localparam longint B0 = 3;
    localparam longint B1 = 6;
    localparam longint B2 = 3;
    longint uk = 0;
    longint dp_acum1, dp_fk, dp_acum2, dp_acum3, dp_yk, dp_fk1, dp_fk2;
    longint gold_q[$];
    longint gf1, gf2, gf, gy;
    bit dp_chk = 1'b0;
    int done_cnt = 0;

    function automatic longint dp_mac();
        longint sv, cv, zv;
        case (controlS)
            3'd1: sv = A1;
            3'd2: sv = A2;
            3'd3: sv = B0;
            3'd4: sv = B1;
            3'd5: sv = B2;
            default: sv = 0;
        endcase
        case (controlC)
            2'd1: cv = dp_fk1;
            2'd2: cv = dp_fk2;
            2'd3: cv = dp_fk;
            default: cv = 0;
        endcase
        case (controlZ)
            3'd1: zv = uk;
            3'd2: zv = dp_yk;
            3'd3: zv = dp_acum1;
            3'd4: zv = dp_acum2;
            3'd5: zv = dp_acum3;
            default: zv = 0;
        endcase
        return ((sv * cv) >>> 14) + zv;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            dp_acum1 <= 0; dp_fk <= 0; dp_acum2 <= 0; dp_acum3 <= 0;
            dp_yk <= 0; dp_fk1 <= 0; dp_fk2 <= 0;
        end else begin
            if (en_acum1) dp_acum1 <= dp_mac();
            if (en_fk)    dp_fk    <= dp_mac();
            if (en_acum2) dp_acum2 <= dp_mac();
            if (en_acum3) dp_acum3 <= dp_mac();
            if (en_yk)    dp_yk    <= dp_mac();
            if (en_shift) begin
                dp_fk2 <= dp_fk1;
                dp_fk1 <= dp_fk;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic check_outputs();
        logic [5:0] en;
        en = {en_acum1, en_fk, en_acum2, en_acum3, en_yk, en_shift};
        chk("controlS", 64'(controlS), 64'(exp_s[phase]));
        chk("controlC", 64'(controlC), 64'(exp_c[phase]));
        chk("controlZ", 64'(controlZ), 64'(exp_z[phase]));
        chk("enables", 64'(en), 64'(exp_en[phase]));
        chk("en_onehot", 64'($countones(en)), (phase == 0) ? 64'd0 : 64'd1);
        chk("busy", 64'(busy), (phase == 0) ? 64'd0 : 64'd1);
        chk("done", 64'(done), (phase == 6) ? 64'd1 : 64'd0);
        chk("overrun", 64'(overrun), 64'(ovr_m));
        if (done === 1'b1) begin
            done_cnt++;
            if (dp_chk) begin
                if (gold_q.size() > 0) begin
                    chk("yk", 64'(dp_yk), 64'(gold_q.pop_front()));
                end else begin
                    chk("gold_avail", 64'(gold_q.size()), 64'd1);
                end
            end
        end
    endtask

    // Drive inputs at the falling edge, advance the model at the rising edge, check at the next fall.
    task automatic step(input logic st, input logic rs);
        start = st;
        reset = rs;
        @(posedge clk);
        if (rs) begin
            phase = 0;
            ovr_m = 1'b0;
        end else if (phase == 0) begin
            phase = st ? 1 : 0;
        end else begin
            if (st) ovr_m = 1'b1;
            phase = (phase >= 6) ? 0 : phase + 1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        start = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Single sample, full sequence.
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // Ten samples at 7-cycle spacing, step input of 1000, yk against golden biquad.
        step(1'b0, 1'b1);
        gf1 = 0; gf2 = 0;
        uk = 1000;
        dp_chk = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            gf = uk + ((A1 * gf1) >>> 14) + ((A2 * gf2) >>> 14);
            gy = ((B0 * gf) >>> 14) + ((B1 * gf1) >>> 14) + ((B2 * gf2) >>> 14);
            gold_q.push_back(gy);
            gf2 = gf1;
            gf1 = gf;
            step(1'b1, 1'b0);
            for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        end
        step(1'b0, 1'b0);
        dp_chk = 1'b0;
        chk("done_count", 64'(done_cnt), 64'd10);
        chk("yk_final", 64'(dp_yk), 64'(gy));

        // Start every 6 cycles: each second start lands on UPD.
        step(1'b0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        end
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);

        // Start held high for 20 cycles.
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);

        // Reset during M3, start coincident with reset, then a fresh sequence.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);

        // Illegal encoding forced during M2.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        phase = 7;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);

        // Randomized starts with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
